// File: rtl/fetch_pc_unit_if.sv
// Fetch-stage PC bundle: D/M redirect inputs and F-side outputs
// feeding the IF/ID register.
interface fetch_pc_unit_if;
    logic        StallF;
    logic        BranchTakenD;
    logic [31:0] BranchTargetD;
    logic        IsJumpBranchD;
    logic        InterruptRequest;
    logic        EretM;
    logic [31:0] EPC;
    logic [31:0] PCF;
    logic [31:0] PCPlus4F;
    logic        AtDelaySlotF;
    logic        CancelF;
    logic [4:0]  ExcCodeF;
    logic        RedirectPendingF;

    modport master (
        output StallF, BranchTakenD, BranchTargetD, IsJumpBranchD,
        output InterruptRequest, EretM, EPC,
        input  PCF, PCPlus4F, AtDelaySlotF, CancelF, ExcCodeF,
        input  RedirectPendingF
    );

    modport slave (
        input  StallF, BranchTakenD, BranchTargetD, IsJumpBranchD,
        input  InterruptRequest, EretM, EPC,
        output PCF, PCPlus4F, AtDelaySlotF, CancelF, ExcCodeF,
        output RedirectPendingF
    );
endinterface

// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC generator with a one-entry buffer for interrupt/ERET
// redirects that arrive while F is stalled.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
    parameter logic [31:0] TEXT_LO    = 32'h0000_3000,
    parameter logic [31:0] TEXT_HI    = 32'h0000_4FFC
) (
    input logic clk,
    input logic reset,
    fetch_pc_unit_if.slave bus
);
    logic [31:0] pc_q;
    logic        pend_valid;
    logic [31:0] pend_pc;
    logic        redirect;
    logic [31:0] redirect_pc;

    // An interrupt beats an ERET arriving in the same cycle.
    assign redirect    = bus.InterruptRequest | bus.EretM;
    assign redirect_pc = bus.InterruptRequest ? HANDLER_PC : bus.EPC;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            pend_valid <= 1'b0;
            pend_pc    <= 32'd0;
        end else if (redirect) begin
            if (bus.StallF) begin
                pend_valid <= 1'b1;
                pend_pc    <= redirect_pc;
            end else begin
                pc_q       <= redirect_pc;
                pend_valid <= 1'b0;
            end
        end else if (pend_valid && !bus.StallF) begin
            pc_q       <= pend_pc;
            pend_valid <= 1'b0;
        end else if (bus.StallF) begin
            pc_q <= pc_q;
        end else if (bus.BranchTakenD && !pend_valid) begin
            pc_q <= bus.BranchTargetD;
        end else begin
            pc_q <= pc_q + 32'd4;
        end
    end

    logic cancel;

    assign cancel = (pc_q[1:0] != 2'b00) | (pc_q < TEXT_LO) | (pc_q > TEXT_HI);

    assign bus.PCF              = pc_q;
    assign bus.PCPlus4F         = pc_q + 32'd4;
    assign bus.CancelF          = cancel;
    assign bus.ExcCodeF         = cancel ? 5'd4 : 5'd0;
    assign bus.AtDelaySlotF     = bus.IsJumpBranchD & ~pend_valid;
    assign bus.RedirectPendingF = pend_valid;
endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed and randomized checks of fetch_pc_unit against a queue-based
// next-PC reference model.
module tb_fetch_pc_unit;
    localparam logic [31:0] RST_PC = 32'h0000_3000;
    localparam logic [31:0] HND_PC = 32'h0000_4180;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    fetch_pc_unit_if bus ();

    fetch_pc_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    logic [31:0] m_pc;
    logic [31:0] m_pend[$];

    function automatic bit legal(input logic [31:0] a);
        return (a % 4 == 0) && (a >= 32'h3000) && (a <= 32'h4FFC);
    endfunction

    task automatic model_update();
        logic [31:0] tgt;
        if (reset) begin
            m_pc = RST_PC;
            m_pend.delete();
        end else if (bus.InterruptRequest || bus.EretM) begin
            tgt = bus.InterruptRequest ? HND_PC : bus.EPC;
            if (bus.StallF) begin
                m_pend.delete();
                m_pend.push_back(tgt);
            end else begin
                m_pc = tgt;
                m_pend.delete();
            end
        end else if (m_pend.size() > 0) begin
            if (!bus.StallF) m_pc = m_pend.pop_front();
        end else if (!bus.StallF) begin
            m_pc = bus.BranchTakenD ? bus.BranchTargetD : m_pc + 32'd4;
        end
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset = 1'b0;
        bus.StallF = 1'b0;
        bus.BranchTakenD = 1'b0;
        bus.BranchTargetD = 32'd0;
        bus.IsJumpBranchD = 1'b0;
        bus.InterruptRequest = 1'b0;
        bus.EretM = 1'b0;
        bus.EPC = 32'd0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus.PCF !== RST_PC) begin
            failures++;
            $display("FAIL reset_pcf got=%h exp=%h", bus.PCF, RST_PC);
        end
        checks++;
        if (bus.PCPlus4F !== RST_PC + 32'd4) begin
            failures++;
            $display("FAIL reset_pcplus4 got=%h exp=%h", bus.PCPlus4F, RST_PC + 32'd4);
        end
        checks++;
        if ({bus.CancelF, bus.ExcCodeF, bus.RedirectPendingF} !== 7'd0) begin
            failures++;
            $display("FAIL reset_flags got=%b%h%b exp=0", bus.CancelF, bus.ExcCodeF,
                     bus.RedirectPendingF);
        end
        bus.IsJumpBranchD = 1'b1;
        #1;
        checks++;
        if (bus.AtDelaySlotF !== 1'b1) begin
            failures++;
            $display("FAIL reset_delay_slot got=%b exp=1", bus.AtDelaySlotF);
        end
        bus.IsJumpBranchD = 1'b0;
        #1;
    endtask

    task automatic test_sequential();
        logic [31:0] exp;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            exp = 32'h3000 + 32'(4 * i);
            checks++;
            if (bus.PCF !== exp || bus.PCPlus4F !== exp + 32'd4 || bus.CancelF !== 1'b0) begin
                failures++;
                $display("FAIL seq_%0d got=%h/%h/%b exp=%h/%h/0", i, bus.PCF, bus.PCPlus4F,
                         bus.CancelF, exp, exp + 32'd4);
            end
            if (i < 3) step();
        end
    endtask

    task automatic test_branch_delay();
        do_reset();
        step();
        step();
        bus.BranchTakenD = 1'b1;
        bus.BranchTargetD = 32'h3100;
        bus.IsJumpBranchD = 1'b1;
        #1;
        checks++;
        if (bus.PCF !== 32'h3008 || bus.AtDelaySlotF !== 1'b1) begin
            failures++;
            $display("FAIL branch_slot got=%h/%b exp=3008/1", bus.PCF, bus.AtDelaySlotF);
        end
        step();
        idle();
        #1;
        checks++;
        if (bus.PCF !== 32'h3100) begin
            failures++;
            $display("FAIL branch_target got=%h exp=3100", bus.PCF);
        end
    endtask

    task automatic test_stalled_interrupt();
        do_reset();
        for (int i = 0; i < 4; i++) step();
        bus.StallF = 1'b1;
        bus.InterruptRequest = 1'b1;
        bus.IsJumpBranchD = 1'b1;
        step();
        bus.InterruptRequest = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (bus.PCF !== 32'h3010 || bus.RedirectPendingF !== 1'b1 ||
                bus.AtDelaySlotF !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold_%0d got=%h/%b/%b exp=3010/1/0", i, bus.PCF,
                         bus.RedirectPendingF, bus.AtDelaySlotF);
            end
            step();
        end
        bus.StallF = 1'b0;
        bus.IsJumpBranchD = 1'b0;
        #1;
        checks++;
        if (bus.PCF !== 32'h3010 || bus.RedirectPendingF !== 1'b1) begin
            failures++;
            $display("FAIL stall_last got=%h/%b exp=3010/1", bus.PCF, bus.RedirectPendingF);
        end
        step();
        checks++;
        if (bus.PCF !== HND_PC || bus.RedirectPendingF !== 1'b0) begin
            failures++;
            $display("FAIL stall_release got=%h/%b exp=4180/0", bus.PCF, bus.RedirectPendingF);
        end
    endtask

    task automatic test_eret_vs_irq();
        do_reset();
        bus.EretM = 1'b1;
        bus.InterruptRequest = 1'b1;
        bus.EPC = 32'h3020;
        step();
        idle();
        #1;
        checks++;
        if (bus.PCF !== HND_PC) begin
            failures++;
            $display("FAIL eret_vs_irq got=%h exp=4180", bus.PCF);
        end
        // Buffered ERET; a branch in D afterwards belongs to the squashed path.
        bus.StallF = 1'b1;
        bus.EretM = 1'b1;
        bus.EPC = 32'h3200;
        step();
        idle();
        bus.BranchTakenD = 1'b1;
        bus.BranchTargetD = 32'h3300;
        step();
        idle();
        #1;
        checks++;
        if (bus.PCF !== 32'h3200) begin
            failures++;
            $display("FAIL eret_branch_ignored got=%h exp=3200", bus.PCF);
        end
    endtask

    task automatic test_cancel();
        logic [31:0] tgt[5] = '{32'h3102, 32'h5000, 32'h4FFC, 32'h2FFC, 32'hFFFF_FFFC};
        logic        can[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [31:0] nxt;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            bus.BranchTakenD = 1'b1;
            bus.BranchTargetD = tgt[i];
            step();
            idle();
            #1;
            checks++;
            if (bus.PCF !== tgt[i] || bus.CancelF !== can[i] ||
                bus.ExcCodeF !== (can[i] ? 5'd4 : 5'd0)) begin
                failures++;
                $display("FAIL cancel_%0d got=%h/%b/%0d exp=%h/%b", i, bus.PCF,
                         bus.CancelF, bus.ExcCodeF, tgt[i], can[i]);
            end
            step();
            nxt = tgt[i] + 32'd4;
            checks++;
            if (bus.PCF !== nxt || bus.CancelF !== !legal(nxt)) begin
                failures++;
                $display("FAIL cancel_adv_%0d got=%h/%b exp=%h/%b", i, bus.PCF,
                         bus.CancelF, nxt, !legal(nxt));
            end
        end
    endtask

    task automatic test_reset_pending();
        do_reset();
        step();
        bus.StallF = 1'b1;
        bus.InterruptRequest = 1'b1;
        step();
        bus.InterruptRequest = 1'b0;
        #1;
        checks++;
        if (bus.RedirectPendingF !== 1'b1) begin
            failures++;
            $display("FAIL rstpend_set got=%b exp=1", bus.RedirectPendingF);
        end
        reset = 1'b1;
        step();
        idle();
        #1;
        checks++;
        if (bus.PCF !== RST_PC || bus.RedirectPendingF !== 1'b0) begin
            failures++;
            $display("FAIL rstpend_clear got=%h/%b exp=3000/0", bus.PCF, bus.RedirectPendingF);
        end
        step();
        checks++;
        if (bus.PCF !== 32'h3004) begin
            failures++;
            $display("FAIL rstpend_after got=%h exp=3004", bus.PCF);
        end
    endtask

    task automatic test_random();
        logic [31:0] t;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            reset = ($urandom_range(0, 59) == 0);
            bus.StallF = ($urandom_range(0, 2) == 0);
            bus.BranchTakenD = ($urandom_range(0, 3) == 0);
            t = 32'h3000 + ($urandom_range(0, 2047) << 2);
            if ($urandom_range(0, 9) == 0) t = $urandom;
            bus.BranchTargetD = t;
            bus.IsJumpBranchD = $urandom_range(0, 1);
            bus.InterruptRequest = ($urandom_range(0, 19) == 0);
            bus.EretM = ($urandom_range(0, 14) == 0);
            bus.EPC = 32'h3000 + ($urandom_range(0, 2047) << 2);
            #1;
            checks++;
            if (bus.PCF !== m_pc || bus.PCPlus4F !== m_pc + 32'd4 ||
                bus.CancelF !== !legal(m_pc) ||
                bus.ExcCodeF !== (legal(m_pc) ? 5'd0 : 5'd4) ||
                bus.RedirectPendingF !== (m_pend.size() != 0) ||
                bus.AtDelaySlotF !== (bus.IsJumpBranchD && m_pend.size() == 0)) begin
                failures++;
                $display("FAIL rand_%0d got pc=%h p4=%h c=%b e=%0d rp=%b ds=%b exp pc=%h pend=%0d",
                         c, bus.PCF, bus.PCPlus4F, bus.CancelF, bus.ExcCodeF,
                         bus.RedirectPendingF, bus.AtDelaySlotF, m_pc, m_pend.size());
            end
            step();
        end
        idle();
    endtask

    initial begin
        idle();
        m_pc = 32'd0;
        test_reset();
        test_sequential();
        test_branch_delay();
        test_stalled_interrupt();
        test_eret_vs_irq();
        test_cancel();
        test_reset_pending();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
